// File: rtl/led_scan_controller.sv
// ---------------------------------------------------------------------------
// led_scan_controller
//
// Scan sequencer for a one-bit-per-colour shift-register LED panel. Pixels
// are pulled from an upstream source over a req/valid handshake and shifted
// into the panel one column at a time. At the end of each row the panel is
// blanked, the ripple row address is stepped (aclk) or reset (arst), the
// shifted row is latched and the panel is unblanked. Each row stays lit
// for at least ON_CYCLES clocks before the next blank.
//
// Ports:
//   clk              panel-domain clock
//   reset_n          asynchronous active-low reset
//   enable_in        scan enable, sampled at frame boundaries only
//   rowmax_in        index of last row, sampled at frame boundaries only
//   pix_req_out      pixel request for (pix_row_out, pix_col_out)
//   pix_valid_in     pixel valid; a transfer is pix_req_out & pix_valid_in
//   pix_rgb_in       {red, green, blue} pixel bits
//   pix_row_out      row currently being shifted
//   pix_col_out      column currently being requested
//   red/green/blue_out  serial pixel data
//   sclk_out         shift clock
//   latch_out        latch strobe
//   blank_out        1 = panel dark
//   aclk_out         row address increment pulse
//   arst_out         row address reset pulse
//   row_out          row currently latched / displayed
//   frame_start_out  one-cycle pulse coincident with arst_out
// ---------------------------------------------------------------------------
module led_scan_controller #(
    parameter int COLS      = 32,
    parameter int COL_BITS  = 5,
    parameter int ON_CYCLES = 128
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable_in,
    input  logic [3:0]          rowmax_in,
    output logic                pix_req_out,
    input  logic                pix_valid_in,
    input  logic [2:0]          pix_rgb_in,
    output logic [3:0]          pix_row_out,
    output logic [COL_BITS-1:0] pix_col_out,
    output logic                red_out,
    output logic                green_out,
    output logic                blue_out,
    output logic                sclk_out,
    output logic                latch_out,
    output logic                blank_out,
    output logic                aclk_out,
    output logic                arst_out,
    output logic [3:0]          row_out,
    output logic                frame_start_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SCLK,
        S_WAIT_ON,
        S_BLANK,
        S_ADDR,
        S_LATCH
    } state_e;

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [15:0]         ON_MAX   = 16'(ON_CYCLES);

    state_e              state_q, state_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [3:0]          shift_row_q, shift_row_d;
    logic [3:0]          rowmax_q, rowmax_d;
    logic [15:0]         on_cnt_q, on_cnt_d;
    logic [15:0]         on_cnt_inc;
    logic                on_ok;
    logic                xfer;

    logic                pix_req_q, pix_req_d;
    logic [2:0]          rgb_q, rgb_d;
    logic                sclk_q, sclk_d;
    logic                latch_q, latch_d;
    logic                blank_q, blank_d;
    logic                aclk_q, aclk_d;
    logic                arst_q, arst_d;
    logic [3:0]          row_q, row_d;
    logic                fs_q, fs_d;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            shift_row_q <= '0;
            rowmax_q    <= '0;
            // Reset to "satisfied" so the very first row never waits.
            on_cnt_q    <= ON_MAX;
            pix_req_q   <= 1'b0;
            rgb_q       <= '0;
            sclk_q      <= 1'b0;
            latch_q     <= 1'b0;
            blank_q     <= 1'b1;
            aclk_q      <= 1'b0;
            arst_q      <= 1'b0;
            row_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            shift_row_q <= shift_row_d;
            rowmax_q    <= rowmax_d;
            on_cnt_q    <= on_cnt_d;
            pix_req_q   <= pix_req_d;
            rgb_q       <= rgb_d;
            sclk_q      <= sclk_d;
            latch_q     <= latch_d;
            blank_q     <= blank_d;
            aclk_q      <= aclk_d;
            arst_q      <= arst_d;
            row_q       <= row_d;
            fs_q        <= fs_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    assign xfer       = (state_q == S_FETCH) && pix_valid_in;
    assign on_cnt_inc = (on_cnt_q >= ON_MAX) ? ON_MAX : on_cnt_q + 16'd1;

    // The on-time test looks at the count this cycle will end with, so the
    // panel is lit for exactly ON_CYCLES clocks before the BLANK cycle.
    assign on_ok = ((blank_q ? on_cnt_q : on_cnt_inc) >= ON_MAX);

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        shift_row_d = shift_row_q;
        rowmax_d    = rowmax_q;
        on_cnt_d    = blank_q ? on_cnt_q : on_cnt_inc;

        unique case (state_q)
            S_IDLE: begin
                if (enable_in) begin
                    rowmax_d    = rowmax_in;
                    shift_row_d = '0;
                    col_d       = '0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (pix_valid_in) state_d = S_SCLK;
            end
            S_SCLK: begin
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = on_ok ? S_BLANK : S_WAIT_ON;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_ON: begin
                if (on_ok) state_d = S_BLANK;
            end
            S_BLANK: state_d = S_ADDR;
            S_ADDR:  state_d = S_LATCH;
            S_LATCH: begin
                if (shift_row_q == rowmax_q) begin
                    if (!enable_in) begin
                        state_d = S_IDLE;
                    end else begin
                        rowmax_d    = rowmax_in;
                        shift_row_d = '0;
                        state_d     = S_FETCH;
                    end
                end else begin
                    shift_row_d = shift_row_q + 4'd1;
                    state_d     = S_FETCH;
                end
                // The on-time restarts only when the panel is actually lit;
                // going idle keeps the count saturated so a later restart
                // cannot wait on a counter that never runs while dark.
                if (state_d == S_FETCH) on_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values registered on entry to each state
    // ------------------------------------------------------------------
    always_comb begin
        pix_req_d = (state_d == S_FETCH);
        sclk_d    = (state_d == S_SCLK);
        latch_d   = (state_d == S_LATCH);
        arst_d    = (state_d == S_ADDR) && (shift_row_q == 4'd0);
        aclk_d    = (state_d == S_ADDR) && (shift_row_q != 4'd0);
        fs_d      = arst_d;
        rgb_d     = xfer ? pix_rgb_in : rgb_q;
        row_d     = (state_q == S_ADDR) ? shift_row_q : row_q;

        blank_d = blank_q;
        if (state_d == S_BLANK) begin
            blank_d = 1'b1;
        end else if ((state_q == S_LATCH) && (state_d == S_FETCH)) begin
            blank_d = 1'b0;
        end
    end

    assign pix_req_out     = pix_req_q;
    assign pix_row_out     = shift_row_q;
    assign pix_col_out     = col_q;
    assign red_out         = rgb_q[2];
    assign green_out       = rgb_q[1];
    assign blue_out        = rgb_q[0];
    assign sclk_out        = sclk_q;
    assign latch_out       = latch_q;
    assign blank_out       = blank_q;
    assign aclk_out        = aclk_q;
    assign arst_out        = arst_q;
    assign row_out         = row_q;
    assign frame_start_out = fs_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_led_scan_controller
//
// Two instances share the control inputs: dut 0 (COLS=4, ON_CYCLES=4) and
// dut 1 (COLS=4, ON_CYCLES=20). Each has its own pixel source that answers
// the requested (row, col) with a fixed pattern, so the serial data seen at
// every sclk can be predicted from the coordinates.
// ---------------------------------------------------------------------------
module tb_led_scan_controller;

    localparam int COLS = 4;
    localparam int CB   = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          valid;
    logic [3:0]    rowmax;
    logic [2:0]    rgb_in [2];

    logic [1:0]    req_w, red_w, green_w, blue_w, sclk_w, latch_w;
    logic [1:0]    blank_w, aclk_w, arst_w, fs_w;
    logic [3:0]    prow_w [2];
    logic [CB-1:0] pcol_w [2];
    logic [3:0]    row_w [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] pix_of(input logic [3:0] r, input logic [CB-1:0] c);
        return {r[0] ^ c[1], c[0], r[1] ^ c[2] ^ c[1]};
    endfunction

    assign rgb_in[0] = pix_of(prow_w[0], pcol_w[0]);
    assign rgb_in[1] = pix_of(prow_w[1], pcol_w[1]);

    led_scan_controller #(.COLS(COLS), .COL_BITS(CB), .ON_CYCLES(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .enable_in(enable), .rowmax_in(rowmax),
        .pix_req_out(req_w[0]), .pix_valid_in(valid), .pix_rgb_in(rgb_in[0]),
        .pix_row_out(prow_w[0]), .pix_col_out(pcol_w[0]),
        .red_out(red_w[0]), .green_out(green_w[0]), .blue_out(blue_w[0]),
        .sclk_out(sclk_w[0]), .latch_out(latch_w[0]), .blank_out(blank_w[0]),
        .aclk_out(aclk_w[0]), .arst_out(arst_w[0]), .row_out(row_w[0]),
        .frame_start_out(fs_w[0])
    );

    led_scan_controller #(.COLS(COLS), .COL_BITS(CB), .ON_CYCLES(20)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .enable_in(enable), .rowmax_in(rowmax),
        .pix_req_out(req_w[1]), .pix_valid_in(valid), .pix_rgb_in(rgb_in[1]),
        .pix_row_out(prow_w[1]), .pix_col_out(pcol_w[1]),
        .red_out(red_w[1]), .green_out(green_w[1]), .blue_out(blue_w[1]),
        .sclk_out(sclk_w[1]), .latch_out(latch_w[1]), .blank_out(blank_w[1]),
        .aclk_out(aclk_w[1]), .arst_out(arst_w[1]), .row_out(row_w[1]),
        .frame_start_out(fs_w[1])
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // All dut 0 outputs packed together, used to prove nothing moves in a stall.
    function automatic logic [31:0] outs_a();
        return {11'd0, req_w[0], red_w[0], green_w[0], blue_w[0], sclk_w[0], latch_w[0],
                blank_w[0], aclk_w[0], arst_w[0], fs_w[0], row_w[0], prow_w[0], pcol_w[0]};
    endfunction

    // Follow one dut from the current negedge up to its next latch pulse.
    task automatic run_row(input int d, input int col0, output int cyc, output int nsclk,
                           output int narst, output int naclk, output int nfs,
                           output int nblank_lo, output int gap, output int row);
        int  last_sclk;
        int  rise;
        bit  was_lo;
        bit  done;
        cyc = 0; nsclk = 0; narst = 0; naclk = 0; nfs = 0; nblank_lo = 0; row = -1;
        last_sclk = -1; rise = -1; was_lo = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sclk_w[d]) begin
                check($sformatf("d%0d_sclk_col", d), 32'(pcol_w[d]), 32'(col0 + nsclk));
                check($sformatf("d%0d_sclk_rgb", d), {29'd0, red_w[d], green_w[d], blue_w[d]},
                      32'(pix_of(prow_w[d], pcol_w[d])));
                nsclk++;
                last_sclk = cyc;
            end
            if (!blank_w[d]) begin
                nblank_lo++;
                was_lo = 1;
            end else if (was_lo && rise < 0) begin
                rise = cyc;
            end
            if (arst_w[d]) narst++;
            if (aclk_w[d]) naclk++;
            if (fs_w[d])   nfs++;
            if (latch_w[d]) begin
                row  = 32'(row_w[d]);
                done = 1;
            end
        end
        check($sformatf("d%0d_latch_seen", d), 32'(done), 32'd1);
        gap = (rise >= 0 && last_sclk >= 0) ? rise - last_sclk : -1;
    endtask

    task automatic expect_row(input int d, input int col0, input int erow, input int ecyc,
                              input int esclk, input int efirst, input int eblank, input int egap);
        int    cyc, nsclk, narst, naclk, nfs, nbl, gap, row;
        string t;
        t = $sformatf("d%0d_row%0d", d, erow);
        run_row(d, col0, cyc, nsclk, narst, naclk, nfs, nbl, gap, row);
        check({t, "_row_out"}, 32'(row), 32'(erow));
        if (ecyc >= 0)   check({t, "_period"}, 32'(cyc), 32'(ecyc));
        check({t, "_sclk_count"}, 32'(nsclk), 32'(esclk));
        check({t, "_arst"}, 32'(narst), 32'(efirst));
        check({t, "_aclk"}, 32'(naclk), 32'(efirst ? 0 : 1));
        check({t, "_frame_start"}, 32'(nfs), 32'(efirst));
        if (eblank >= 0) check({t, "_lit_cycles"}, 32'(nbl), 32'(eblank));
        if (egap >= 0)   check({t, "_wait_on_gap"}, 32'(gap), 32'(egap));
    endtask

    initial begin
        int          exp_rows [7];
        logic [31:0] snap;
        bit          found;
        int          n_sclk, n_latch, n_req, n_lo;

        reset_n = 1'b1;
        enable  = 1'b0;
        valid   = 1'b1;
        rowmax  = 4'd3;

        // ---- reset values, checked while reset is held ----
        #1 reset_n = 1'b0;
        #1;
        check("rst_blank",  32'(blank_w[0]), 32'd1);
        check("rst_req",    32'(req_w[0]),   32'd0);
        check("rst_sclk",   32'(sclk_w[0]),  32'd0);
        check("rst_latch",  32'(latch_w[0]), 32'd0);
        check("rst_addr",   {30'd0, aclk_w[0], arst_w[0]}, 32'd0);
        check("rst_fs",     32'(fs_w[0]),    32'd0);
        check("rst_rgb",    {29'd0, red_w[0], green_w[0], blue_w[0]}, 32'd0);
        check("rst_row",    32'(row_w[0]),   32'd0);
        check("rst_pix_rc", {25'd0, prow_w[0], pcol_w[0]}, 32'd0);
        check("rst_blank_b", 32'(blank_w[1]), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_blank", 32'(blank_w[0]), 32'd1);
        check("idle_req",   32'(req_w[0]),   32'd0);

        // ---- two full frames, rows 0..3, period 11 ----
        enable = 1'b1;
        for (int i = 0; i < 8; i++)
            expect_row(0, 0, i % 4, 11, 4, (i % 4 == 0) ? 1 : 0, (i == 0) ? 0 : 8, -1);

        // ---- valid held low for 5 cycles while column 2 is requested ----
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (req_w[0] && pcol_w[0] == CB'(2)) found = 1;
        end
        check("stall_reached_col2", 32'(found), 32'd1);
        valid = 1'b0;
        snap  = outs_a();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_hold_%0d", k), outs_a(), snap);
            check($sformatf("stall_sclk_%0d", k), 32'(sclk_w[0]), 32'd0);
        end
        valid = 1'b1;
        expect_row(0, 2, 0, -1, 2, 1, -1, -1);

        // ---- rowmax 3 -> 1 mid-frame: finish 1..3, then frames of 0,1 ----
        rowmax   = 4'd1;
        exp_rows = '{1, 2, 3, 0, 1, 0, 1};
        foreach (exp_rows[i])
            expect_row(0, 0, exp_rows[i], 11, 4, (exp_rows[i] == 0) ? 1 : 0, 8, -1);

        // ---- enable dropped mid-frame: frame completes then stays dark ----
        expect_row(0, 0, 0, 11, 4, 1, 8, -1);
        enable = 1'b0;
        expect_row(0, 0, 1, 11, 4, 0, 8, -1);
        n_sclk = 0; n_latch = 0; n_req = 0; n_lo = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sclk_w[0])   n_sclk++;
            if (latch_w[0])  n_latch++;
            if (req_w[0])    n_req++;
            if (!blank_w[0]) n_lo++;
        end
        check("off_sclk",  32'(n_sclk),  32'd0);
        check("off_latch", 32'(n_latch), 32'd0);
        check("off_req",   32'(n_req),   32'd0);
        check("off_lit",   32'(n_lo),    32'd0);

        // ---- ON_CYCLES=20: 12 WAIT_ON cycles, lit exactly 20 cycles ----
        reset_n = 1'b0;
        enable  = 1'b1;
        rowmax  = 4'd3;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expect_row(1, 0, 0, 11, 4, 1, 0, -1);
        for (int r = 1; r < 4; r++)
            expect_row(1, 0, r, 23, 4, 0, 20, 13);
        expect_row(1, 0, 0, 23, 4, 1, 20, 13);

        // ---- reset during SCLK: outputs drop before the next clock ----
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (sclk_w[0]) found = 1;
        end
        check("reset_sclk_seen", 32'(found), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_sclk",  32'(sclk_w[0]),  32'd0);
        check("arst_latch", 32'(latch_w[0]), 32'd0);
        check("arst_aclk",  32'(aclk_w[0]),  32'd0);
        check("arst_arst",  32'(arst_w[0]),  32'd0);
        check("arst_blank", 32'(blank_w[0]), 32'd1);
        check("arst_req",   32'(req_w[0]),   32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expect_row(0, 0, 0, 11, 4, 1, 0, -1);

        // ---- rowmax 0: every row is its own frame, arst every row ----
        rowmax = 4'd0;
        for (int r = 1; r < 4; r++)
            expect_row(0, 0, r, 11, 4, 0, 8, -1);
        expect_row(0, 0, 0, 11, 4, 1, 8, -1);
        expect_row(0, 0, 0, 11, 4, 1, 8, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
